// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, strobe bases, FSM states and the op legality check for the load/store unit.
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [3:0] STRB_B = 4'b0001;
   localparam logic [3:0] STRB_H = 4'b0011;
   localparam logic [3:0] STRB_W = 4'b1111;
   typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
   function automatic logic op_ok(input logic is_load, input logic [2:0] f3, input logic [1:0] off);
      return (f3 == F3_B) || (is_load && f3 == F3_BU) ||
             ((f3 == F3_H || (is_load && f3 == F3_HU)) && !off[0]) ||
             (f3 == F3_W && off == 2'b00);
   endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/halfword lane out of a read word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_in,
   input  logic [1:0]  off_in,
   input  logic [2:0]  funct3_in,
   output logic [31:0] data_out
);
   logic [31:0] lane;
   always_comb begin
      lane = word_in >> {off_in, 3'b000};
      data_out = funct3_in == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                 funct3_in == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
                 funct3_in == F3_BU ? {24'b0, lane[7:0]} :
                 funct3_in == F3_HU ? {16'b0, lane[15:0]} : lane;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage running one req/ready bus transaction per op and producing load writeback.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   input  logic        is_load_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  rd_addr_in,
   output logic        bus_req_out,
   output logic        bus_we_out,
   output logic [31:0] bus_addr_out,
   output logic [31:0] bus_wdata_out,
   output logic [3:0]  bus_strb_out,
   input  logic        bus_ready_in,
   input  logic [31:0] bus_rdata_in,
   output logic        busy_out,
   output logic [4:0]  rd_addr_out,
   output logic [31:0] rd_data_out,
   output logic        wr_en_out,
   output logic        err_out
);
   state_t      state_q, state_d;
   logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_strb_q, bus_strb_d;
   logic [4:0]  rd_addr_q, rd_addr_d, rd_lat_q, rd_lat_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        wr_en_q, wr_en_d, err_q, err_d, is_load_q, is_load_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] load_data;

   lsu_load_align u_align (
      .word_in  (bus_rdata_in),
      .off_in   (off_q),
      .funct3_in(funct3_q),
      .data_out (load_data)
   );

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_strb_d  = bus_strb_q;
      rd_addr_d   = rd_addr_q;
      rd_lat_d    = rd_lat_q;
      rd_data_d   = rd_data_q;
      is_load_d   = is_load_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      wr_en_d     = 1'b0;
      err_d       = 1'b0;
      if (state_q == IDLE && start_in) begin
         if (op_ok(is_load_in, funct3_in, addr_in[1:0])) begin
            state_d     = REQ;
            is_load_d   = is_load_in;
            funct3_d    = funct3_in;
            off_d       = addr_in[1:0];
            rd_lat_d    = rd_addr_in;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = !is_load_in;
            bus_addr_d  = {addr_in[31:2], 2'b00};
            bus_strb_d  = is_load_in ? 4'b0000 :
                          funct3_in == F3_B ? STRB_B << addr_in[1:0] :
                          funct3_in == F3_H ? STRB_H << addr_in[1:0] : STRB_W;
            bus_wdata_d = funct3_in == F3_B ? {4{store_data_in[7:0]}} :
                          funct3_in == F3_H ? {2{store_data_in[15:0]}} : store_data_in;
         end else begin
            err_d = 1'b1;
         end
      end else if (state_q == REQ) begin
         if (bus_ready_in) begin
            bus_req_d = 1'b0;
            state_d   = is_load_q ? WB : IDLE;
            if (is_load_q) begin
               rd_data_d = load_data;
               rd_addr_d = rd_lat_q;
               wr_en_d   = rd_lat_q != 5'd0;
            end
         end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (state_q == WB) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_strb_q  <= '0;
         rd_addr_q   <= '0;
         rd_lat_q    <= '0;
         rd_data_q   <= '0;
         is_load_q   <= 1'b0;
         funct3_q    <= '0;
         off_q       <= '0;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_strb_q  <= bus_strb_d;
         rd_addr_q   <= rd_addr_d;
         rd_lat_q    <= rd_lat_d;
         rd_data_q   <= rd_data_d;
         is_load_q   <= is_load_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         err_q       <= err_d;
      end
   end

   assign bus_req_out   = bus_req_q;
   assign bus_we_out    = bus_we_q;
   assign bus_addr_out  = bus_addr_q;
   assign bus_wdata_out = bus_wdata_q;
   assign bus_strb_out  = bus_strb_q;
   assign rd_addr_out   = rd_addr_q;
   assign rd_data_out   = rd_data_q;
   assign wr_en_out     = wr_en_q;
   assign err_out       = err_q;
   assign busy_out      = state_q != IDLE;
endmodule
